cdc_req_source: RTL and testbench

- Source-side (clka domain) front end for the toggle req/ack CDC handshake.
- Buffers incoming words from a valid/ready stream in a small FIFO and presents one word at a time on data_a.
- Issues a single-cycle req per word, holds data_a stable until ack_s returns, then pops and serves the next word.
- Supervises each transfer with a timeout counter and reports a sticky error.

---
 rtl/cdc_req_source_if.sv | 29 ++
 rtl/cdc_req_source.sv | 117 +++++++++++
 tb/tb_cdc_req_source.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_req_source_if.sv
// Handshake bundle between an upstream stream source, the CDC request
// front end, and the CDC stage it feeds.
interface cdc_req_source_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  req;
  logic [DATA_WIDTH-1:0] data_a;
  logic                  ack_s;
  logic                  busy;
  logic [LVL_W-1:0]      level;
  logic                  timeout_err;
  logic                  err_clr;

  modport master (
    input  in_valid, in_data, ack_s, err_clr,
    output in_ready, req, data_a, busy, level, timeout_err
  );

  modport slave (
    output in_valid, in_data, ack_s, err_clr,
    input  in_ready, req, data_a, busy, level, timeout_err
  );
endinterface

// File: rtl/cdc_req_source.sv
// Source-side front end of a toggle req/ack CDC handshake: buffers a stream in
// a small FIFO and hands one word at a time to the CDC stage, with ack timeout.
module cdc_req_source #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 64
) (
  input logic              clka,
  input logic              rst_n,
  cdc_req_source_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_POP  = 2'd3;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [LVL_W-1:0]      level_reg;
  logic [1:0]            state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  req_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  err_reg;

  logic push;
  logic ack_done;
  logic tmo_hit;
  logic pop;

  assign bus.in_ready = (level_reg < LVL_FULL);
  assign push         = bus.in_valid && bus.in_ready;

  // A coincident ack outranks expiry, so the word is never flagged as lost.
  assign ack_done = (state_reg == ST_WAIT) && bus.ack_s;
  assign tmo_hit  = TMO_EN && (state_reg == ST_WAIT) && !bus.ack_s && (cnt_reg == CNT_LAST);
  assign pop      = ack_done || tmo_hit;

  always_ff @(posedge clka) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.in_data;
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      req_reg    <= 1'b0;
      data_reg   <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase

      if (tmo_hit) begin
        err_reg <= 1'b1;
      end else if (bus.err_clr) begin
        err_reg <= 1'b0;
      end

      req_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (level_reg != '0) begin
            state_reg <= ST_REQ;
            req_reg   <= 1'b1;
            data_reg  <= mem[rd_ptr_reg];
          end
        end
        ST_REQ: begin
          state_reg <= ST_WAIT;
          cnt_reg   <= '0;
        end
        ST_WAIT: begin
          if (pop) begin
            state_reg <= ST_POP;
          end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req         = req_reg;
  assign bus.data_a      = data_reg;
  assign bus.level       = level_reg;
  assign bus.timeout_err = err_reg;
  assign bus.busy        = (state_reg != ST_IDLE) || (level_reg != '0);
endmodule

// File: tb/tb_cdc_req_source.sv
// Bench for cdc_req_source: randomized words and ack delays checked against a
// queue-based model of accepted words, occupancy and the sticky error flag.
`timescale 1ns/1ps
module tb_cdc_req_source;
  localparam int DW      = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int LVL_W   = $clog2(DEPTH) + 1;

  logic clka  = 1'b0;
  logic rst_n = 1'b0;

  cdc_req_source_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  cdc_req_source #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clka  (clka),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clka = ~clka;

  int checks = 0;
  int errors = 0;

  // Model: words accepted but not yet completed, plus expected error flag.
  logic [DW-1:0] exp_q[$];
  int            mdl_level = 0;
  logic          mdl_err   = 1'b0;
  int            served    = 0;

  // Observation of every req pulse: cycle index and the word shown with it.
  int            cyc        = 0;
  int            req_count  = 0;
  int            double_req = 0;
  logic          prev_req   = 1'b0;
  int            req_cyc[$];
  logic [DW-1:0] seen_data[$];

  always @(posedge clka) cyc <= cyc + 1;

  always @(negedge clka) begin
    if (bus.req === 1'b1) begin
      req_count <= req_count + 1;
      req_cyc.push_back(cyc);
      seen_data.push_back(bus.data_a);
      if (prev_req) double_req <= double_req + 1;
    end
    prev_req <= (bus.req === 1'b1);
  end

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    logic exp_rdy;
    exp_rdy = (mdl_level < DEPTH);
    checks++;
    if (bus.in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL push_in_ready: got %0b expected %0b", bus.in_ready, exp_rdy);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    tick();
    bus.in_valid = 1'b0;
    if (exp_rdy) begin
      exp_q.push_back(w);
      mdl_level++;
    end
    checks++;
    if (bus.level !== LVL_W'(mdl_level)) begin
      errors++;
      $display("FAIL push_level: got %0d expected %0d", bus.level, mdl_level);
    end
    $display("push data=%02h accepted=%0b level=%0d", w, exp_rdy, bus.level);
  endtask

  // Ack the next request d cycles after its req cycle, optionally pushing on that edge.
  task automatic serve(input int d, input bit with_push, input logic [DW-1:0] w);
    int            waited;
    int            r;
    logic [DW-1:0] exp_w;
    waited = 0;
    while (req_count <= served && waited < 50) begin
      tick();
      waited++;
    end
    checks++;
    if (req_count <= served) begin
      errors++;
      $display("FAIL serve_req_wait: got no req expected req #%0d", served + 1);
      return;
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL serve_unexpected_req: got req with data %02h expected none", seen_data[served]);
      served++;
      return;
    end
    r     = req_cyc[served];
    exp_w = exp_q.pop_front();
    checks++;
    if (seen_data[served] !== exp_w) begin
      errors++;
      $display("FAIL serve_data: got %02h expected %02h", seen_data[served], exp_w);
    end
    while (cyc < r + d) tick();
    bus.ack_s = 1'b1;
    if (with_push) begin
      bus.in_valid = 1'b1;
      bus.in_data  = w;
    end
    tick();
    bus.ack_s    = 1'b0;
    bus.in_valid = 1'b0;
    mdl_level--;
    if (with_push) begin
      exp_q.push_back(w);
      mdl_level++;
    end
    served++;
    checks++;
    if (bus.level !== LVL_W'(mdl_level)) begin
      errors++;
      $display("FAIL serve_level: got %0d expected %0d", bus.level, mdl_level);
    end
    checks++;
    if (bus.timeout_err !== mdl_err) begin
      errors++;
      $display("FAIL serve_timeout_err: got %0b expected %0b", bus.timeout_err, mdl_err);
    end
    $display("xfer data=%02h ack_delay=%0d push=%0b level=%0d", exp_w, d, with_push, bus.level);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.req !== 1'b0 || bus.data_a !== '0 || bus.level !== '0 || bus.timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%0b data=%02h level=%0d err=%0b expected 0,00,0,0",
               bus.req, bus.data_a, bus.level, bus.timeout_err);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: got busy=%0b in_ready=%0b expected 0,1", bus.busy, bus.in_ready);
    end
    rst_n = 1'b1;
    tick();
    $display("reset released level=%0d", bus.level);
  endtask

  task automatic test_single();
    int base;
    base = req_count;
    push_word(8'hA5);
    tick();
    checks++;
    if (bus.req !== 1'b1 || bus.data_a !== 8'hA5) begin
      errors++;
      $display("FAIL single_latency: got req=%0b data=%02h expected 1,a5", bus.req, bus.data_a);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.req !== 1'b0 || bus.data_a !== 8'hA5) begin
        errors++;
        $display("FAIL single_hold: got req=%0b data=%02h expected 0,a5", bus.req, bus.data_a);
      end
    end
    serve(6, 1'b0, '0);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (req_count - base != 1 || double_req != 0 || bus.data_a !== 8'hA5) begin
      errors++;
      $display("FAIL single_pulse: got reqs=%0d doubles=%0d data=%02h expected 1,0,a5",
               req_count - base, double_req, bus.data_a);
    end
  endtask

  task automatic test_fill();
    int base;
    base = req_count;
    for (int i = 1; i <= 4; i++) push_word(DW'(i));
    checks++;
    if (bus.in_ready !== 1'b0 || bus.level !== LVL_W'(4)) begin
      errors++;
      $display("FAIL fill_full: got in_ready=%0b level=%0d expected 0,4", bus.in_ready, bus.level);
    end
    push_word(8'h05);
    for (int i = 0; i < 4; i++) serve(5, 1'b0, '0);
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (req_count - base != 4 || double_req != 0) begin
      errors++;
      $display("FAIL fill_req_count: got %0d doubles=%0d expected 4,0", req_count - base, double_req);
    end
  endtask

  task automatic run_timeout(input bit hold_clr);
    logic [DW-1:0] w;
    int            base;
    w    = DW'($urandom);
    base = req_count;
    bus.err_clr = hold_clr;
    push_word(w);
    tick();
    checks++;
    if (bus.req !== 1'b1) begin
      errors++;
      $display("FAIL timeout_req: got %0b expected 1", bus.req);
    end
    for (int i = 0; i < TIMEOUT; i++) tick();
    checks++;
    if (bus.timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got %0b expected 0 in last wait cycle", bus.timeout_err);
    end
    tick();
    mdl_err = 1'b1;
    exp_q.delete();
    mdl_level = 0;
    checks++;
    if (bus.timeout_err !== 1'b1 || bus.level !== '0) begin
      errors++;
      $display("FAIL timeout_set: got err=%0b level=%0d expected 1,0", bus.timeout_err, bus.level);
    end
    checks++;
    if (seen_data[served] !== w) begin
      errors++;
      $display("FAIL timeout_data: got %02h expected %02h", seen_data[served], w);
    end
    served++;
    bus.err_clr = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (req_count - base != 1 || bus.timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_drop: got reqs=%0d err=%0b expected 1,1", req_count - base, bus.timeout_err);
    end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    mdl_err = 1'b0;
    checks++;
    if (bus.timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got %0b expected 0", bus.timeout_err);
    end
    $display("timeout data=%02h clr_held=%0b", w, hold_clr);
  endtask

  task automatic test_timeout();
    run_timeout(1'b0);
    run_timeout(1'b1);
  endtask

  task automatic test_ack_ignored();
    int base;
    base = req_count;
    bus.ack_s = 1'b1;
    tick();
    bus.ack_s = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (bus.level !== '0 || bus.busy !== 1'b0 || bus.timeout_err !== 1'b0 || req_count != base) begin
      errors++;
      $display("FAIL idle_ack: got level=%0d busy=%0b err=%0b reqs=%0d expected 0,0,0,0",
               bus.level, bus.busy, bus.timeout_err, req_count - base);
    end
    push_word(DW'($urandom));
    serve(TIMEOUT, 1'b0, '0);
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL edge_ack: got err=%0b busy=%0b expected 0,0", bus.timeout_err, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    for (int i = 0; i < 3; i++) push_word(DW'($urandom));
    tick();
    checks++;
    if (bus.level !== LVL_W'(3) || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: got level=%0d busy=%0b expected 3,1", bus.level, bus.busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.req !== 1'b0 || bus.data_a !== '0 || bus.level !== '0) begin
      errors++;
      $display("FAIL midrst_async: got req=%0b data=%02h level=%0d expected 0,00,0",
               bus.req, bus.data_a, bus.level);
    end
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    mdl_level = 0;
    served = req_count;
    base = req_count;
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (req_count != base || bus.level !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_quiet: got reqs=%0d level=%0d busy=%0b expected 0,0,0",
               req_count - base, bus.level, bus.busy);
    end
    push_word(DW'($urandom));
    serve($urandom_range(1, 6), 1'b0, '0);
    $display("reset mid-transfer recovered level=%0d", bus.level);
  endtask

  task automatic test_push_on_pop();
    for (int i = 0; i < 3; i++) push_word(DW'($urandom));
    serve($urandom_range(2, 6), 1'b1, DW'($urandom));
    for (int i = 0; i < 3; i++) serve($urandom_range(1, 7), 1'b0, '0);
  endtask

  task automatic test_random();
    int n;
    for (int round = 0; round < 6; round++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) push_word(DW'($urandom));
      for (int i = 0; i < n; i++) serve($urandom_range(1, TIMEOUT), 1'b0, '0);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (exp_q.size() != 0 || bus.busy !== 1'b0 || double_req != 0) begin
      errors++;
      $display("FAIL random_drain: got pending=%0d busy=%0b doubles=%0d expected 0,0,0",
               exp_q.size(), bus.busy, double_req);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.ack_s    = 1'b0;
    bus.err_clr  = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_timeout();
    test_ack_ignored();
    test_reset_mid();
    test_push_on_pop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
